// File: rtl/reindeer_csr_irq.sv
// reindeer_csr_irq
// Machine-mode CSR file and interrupt controller for the Reindeer core.
//   clk, sync_reset        : rising-edge clock, synchronous active-high reset
//   exe_enable             : instruction retired this cycle (minstret tick)
//   csr_enable/op/addr/
//   csr_wdata              : CSR access request (op 01 RW, 10 RS, 11 RC)
//   csr_rdata/rvalid       : pre-write CSR value, one cycle after the access
//   csr_illegal            : one-cycle pulse for an illegal access
//   timer_irq, ext_irq     : interrupt sources (level / rising edge)
//   ext_irq_ack            : one-cycle pulse when software clears a line
//   trap_* , mret          : trap commit and trap return from the pipeline
//   irq_pending/irq_cause  : registered interrupt request and its code
//   trap_target            : registered trap vector address
//   mepc_out, mie_out      : current mepc and mstatus.MIE
module reindeer_csr_irq #(
    parameter int unsigned NUM_EXT_IRQ = 4,
    parameter int unsigned COUNTERS_EN = 1,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   sync_reset,
    input  logic                   exe_enable,
    input  logic                   csr_enable,
    input  logic [1:0]             csr_op,
    input  logic [11:0]            csr_addr,
    input  logic [31:0]            csr_wdata,
    output logic [31:0]            csr_rdata,
    output logic                   csr_rvalid,
    output logic                   csr_illegal,
    input  logic                   timer_irq,
    input  logic [NUM_EXT_IRQ-1:0] ext_irq,
    output logic [NUM_EXT_IRQ-1:0] ext_irq_ack,
    input  logic                   trap_enter,
    input  logic                   trap_is_interrupt,
    input  logic [4:0]             trap_cause,
    input  logic [31:0]            trap_pc,
    input  logic [31:0]            trap_tval,
    input  logic                   mret,
    output logic                   irq_pending,
    output logic [4:0]             irq_cause,
    output logic [31:0]            trap_target,
    output logic [31:0]            mepc_out,
    output logic                   mie_out
);

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_RW   = 2'b01,
        OP_RS   = 2'b10,
        OP_RC   = 2'b11
    } csr_op_e;

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MTVAL     = 12'h343;
    localparam logic [11:0] A_MIP       = 12'h344;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_MVENDORID = 12'hF11;
    localparam logic [11:0] A_MARCHID   = 12'hF12;
    localparam logic [11:0] A_MIMPID    = 12'hF13;
    localparam logic [11:0] A_MHARTID   = 12'hF14;

    localparam bit CNT_ON = (COUNTERS_EN != 0);

    // architectural state
    logic                   mstatus_mie_q, mstatus_mie_d;
    logic                   mstatus_mpie_q, mstatus_mpie_d;
    logic                   mtie_q, mtie_d;
    logic                   meie_q, meie_d;
    logic [NUM_EXT_IRQ-1:0] line_en_q, line_en_d;
    logic [NUM_EXT_IRQ-1:0] pend_q, pend_d;
    logic [NUM_EXT_IRQ-1:0] ext_prev_q, ext_prev_d;
    logic [31:0]            mtvec_q, mtvec_d;
    logic [31:0]            mscratch_q, mscratch_d;
    logic [31:0]            mepc_q, mepc_d;
    logic [31:0]            mcause_q, mcause_d;
    logic [31:0]            mtval_q, mtval_d;
    logic [63:0]            mcycle_q, mcycle_d;
    logic [63:0]            minstret_q, minstret_d;
    logic [31:0]            cyc_snap_q, cyc_snap_d;
    logic [31:0]            ins_snap_q, ins_snap_d;

    // registered outputs
    logic [31:0]            csr_rdata_q, csr_rdata_d;
    logic                   csr_rvalid_q, csr_rvalid_d;
    logic                   csr_illegal_q, csr_illegal_d;
    logic [NUM_EXT_IRQ-1:0] ext_irq_ack_q, ext_irq_ack_d;
    logic                   irq_pending_q, irq_pending_d;
    logic [4:0]             irq_cause_q, irq_cause_d;
    logic [31:0]            trap_target_q, trap_target_d;

    // access decode
    logic [31:0]            mstatus_rd, mie_rd, mip_rd;
    logic [31:0]            old_val, new_val;
    logic                   addr_ok, addr_ro;
    logic                   access, wants_write, bad, read_ok, do_write;
    logic [NUM_EXT_IRQ-1:0] rise, clr, cand;
    logic                   ext_hit, tim_hit, found;
    logic [4:0]             ext_cause;

    always_comb begin
        mstatus_rd        = '0;
        mstatus_rd[12:11] = 2'b11;
        mstatus_rd[7]     = mstatus_mpie_q;
        mstatus_rd[3]     = mstatus_mie_q;

        mie_rd                    = '0;
        mie_rd[7]                 = mtie_q;
        mie_rd[11]                = meie_q;
        mie_rd[16 +: NUM_EXT_IRQ] = line_en_q;

        mip_rd                    = '0;
        mip_rd[7]                 = timer_irq;
        mip_rd[11]                = |pend_q;
        mip_rd[16 +: NUM_EXT_IRQ] = pend_q;
    end

    always_comb begin
        old_val = '0;
        addr_ok = 1'b1;
        addr_ro = 1'b0;
        case (csr_addr)
            A_MSTATUS:   old_val = mstatus_rd;
            A_MIE:       old_val = mie_rd;
            A_MTVEC:     old_val = mtvec_q;
            A_MSCRATCH:  old_val = mscratch_q;
            A_MEPC:      old_val = mepc_q;
            A_MCAUSE:    old_val = mcause_q;
            A_MTVAL:     old_val = mtval_q;
            A_MIP:       old_val = mip_rd;
            A_MCYCLE: begin
                addr_ok = CNT_ON;
                old_val = mcycle_q[31:0];
            end
            A_MINSTRET: begin
                addr_ok = CNT_ON;
                old_val = minstret_q[31:0];
            end
            // high halves return the snapshot taken by the last low-half read
            A_MCYCLEH: begin
                addr_ok = CNT_ON;
                old_val = cyc_snap_q;
            end
            A_MINSTRETH: begin
                addr_ok = CNT_ON;
                old_val = ins_snap_q;
            end
            A_MVENDORID, A_MARCHID, A_MIMPID, A_MHARTID: addr_ro = 1'b1;
            default:     addr_ok = 1'b0;
        endcase
    end

    always_comb begin
        case (csr_op_e'(csr_op))
            OP_RW:   new_val = csr_wdata;
            OP_RS:   new_val = old_val | csr_wdata;
            OP_RC:   new_val = old_val & ~csr_wdata;
            default: new_val = old_val;
        endcase
        access      = csr_enable && (csr_op_e'(csr_op) != OP_NONE);
        // RS/RC with a zero mask are pure reads
        wants_write = (csr_op_e'(csr_op) == OP_RW) || (csr_wdata != '0);
        bad         = access && (!addr_ok || (addr_ro && wants_write));
        read_ok     = access && !bad;
        do_write    = read_ok && wants_write && !trap_enter;
    end

    // next architectural state
    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mtie_d         = mtie_q;
        meie_d         = meie_q;
        line_en_d      = line_en_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtval_d        = mtval_q;
        clr            = '0;

        if (do_write) begin
            case (csr_addr)
                A_MSTATUS: begin
                    mstatus_mie_d  = new_val[3];
                    mstatus_mpie_d = new_val[7];
                end
                A_MIE: begin
                    mtie_d    = new_val[7];
                    meie_d    = new_val[11];
                    line_en_d = new_val[16 +: NUM_EXT_IRQ];
                end
                A_MTVEC:    mtvec_d = {new_val[31:2], 1'b0, new_val[0] & ~new_val[1]};
                A_MSCRATCH: mscratch_d = new_val;
                A_MEPC:     mepc_d = {new_val[31:2], 2'b00};
                A_MCAUSE:   mcause_d = {new_val[31], 26'd0, new_val[4:0]};
                A_MTVAL:    mtval_d = new_val;
                A_MIP:      clr = pend_q & ~new_val[16 +: NUM_EXT_IRQ];
                default: ;
            endcase
        end

        // trap entry outranks both mret and the (already dropped) CSR write;
        // mret outranks a same-cycle mstatus write
        if (trap_enter) begin
            mepc_d         = trap_pc & 32'hFFFF_FFFC;
            mcause_d       = {trap_is_interrupt, 26'd0, trap_cause};
            mtval_d        = trap_tval;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (mret) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end

        // a new edge beats a same-cycle software clear and suppresses its ack
        rise          = ext_irq & ~ext_prev_q;
        pend_d        = (pend_q & ~clr) | rise;
        ext_irq_ack_d = clr & ~rise;
        ext_prev_d    = ext_irq;
    end

    // counters
    always_comb begin
        mcycle_d   = mcycle_q + 64'd1;
        minstret_d = minstret_q + {63'd0, exe_enable};
        cyc_snap_d = cyc_snap_q;
        ins_snap_d = ins_snap_q;
        if (read_ok && csr_addr == A_MCYCLE)   cyc_snap_d = mcycle_q[63:32];
        if (read_ok && csr_addr == A_MINSTRET) ins_snap_d = minstret_q[63:32];
        if (do_write) begin
            case (csr_addr)
                A_MCYCLE:    mcycle_d   = {mcycle_q[63:32], new_val};
                A_MCYCLEH:   mcycle_d   = {new_val, mcycle_q[31:0]};
                A_MINSTRET:  minstret_d = {minstret_q[63:32], new_val};
                A_MINSTRETH: minstret_d = {new_val, minstret_q[31:0]};
                default: ;
            endcase
        end
        if (!CNT_ON) begin
            mcycle_d   = '0;
            minstret_d = '0;
            cyc_snap_d = '0;
            ins_snap_d = '0;
        end
    end

    // interrupt arbitration and access response
    always_comb begin
        cand      = pend_q & line_en_q;
        found     = 1'b0;
        ext_cause = '0;
        for (int unsigned i = 0; i < NUM_EXT_IRQ; i++) begin
            if (cand[i] && !found) begin
                found     = 1'b1;
                ext_cause = 5'(16 + i);
            end
        end
        ext_hit = meie_q && found;
        tim_hit = timer_irq && mtie_q;

        if (ext_hit)      irq_cause_d = ext_cause;
        else if (tim_hit) irq_cause_d = 5'd7;
        else              irq_cause_d = '0;
        irq_pending_d = mstatus_mie_q && (ext_hit || tim_hit);

        trap_target_d = {mtvec_q[31:2], 2'b00};
        if (mtvec_q[0] && irq_pending_d)
            trap_target_d = {mtvec_q[31:2], 2'b00} + {25'd0, irq_cause_d, 2'b00};

        csr_rvalid_d  = access;
        csr_illegal_d = bad;
        csr_rdata_d   = read_ok ? old_val : '0;
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mtie_q         <= 1'b0;
            meie_q         <= 1'b0;
            line_en_q      <= '0;
            pend_q         <= '0;
            ext_prev_q     <= '0;
            mtvec_q        <= MTVEC_RESET;
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mtval_q        <= '0;
            mcycle_q       <= '0;
            minstret_q     <= '0;
            cyc_snap_q     <= '0;
            ins_snap_q     <= '0;
            csr_rdata_q    <= '0;
            csr_rvalid_q   <= 1'b0;
            csr_illegal_q  <= 1'b0;
            ext_irq_ack_q  <= '0;
            irq_pending_q  <= 1'b0;
            irq_cause_q    <= '0;
            trap_target_q  <= '0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mtie_q         <= mtie_d;
            meie_q         <= meie_d;
            line_en_q      <= line_en_d;
            pend_q         <= pend_d;
            ext_prev_q     <= ext_prev_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
            mcycle_q       <= mcycle_d;
            minstret_q     <= minstret_d;
            cyc_snap_q     <= cyc_snap_d;
            ins_snap_q     <= ins_snap_d;
            csr_rdata_q    <= csr_rdata_d;
            csr_rvalid_q   <= csr_rvalid_d;
            csr_illegal_q  <= csr_illegal_d;
            ext_irq_ack_q  <= ext_irq_ack_d;
            irq_pending_q  <= irq_pending_d;
            irq_cause_q    <= irq_cause_d;
            trap_target_q  <= trap_target_d;
        end
    end

    assign csr_rdata   = csr_rdata_q;
    assign csr_rvalid  = csr_rvalid_q;
    assign csr_illegal = csr_illegal_q;
    assign ext_irq_ack = ext_irq_ack_q;
    assign irq_pending = irq_pending_q;
    assign irq_cause   = irq_cause_q;
    assign trap_target = trap_target_q;
    assign mepc_out    = mepc_q;
    assign mie_out     = mstatus_mie_q;

endmodule
